// File: rtl/ps2_digit_entry_ctrl_pkg.sv
// ps2_pkg: shared definitions for the PS/2 digit-entry controller.
//   - scancode constants (break/extended prefixes, backspace, escape, digits)
//   - DIGIT_BLANK code understood by the seven-segment controller
//   - decode FSM state enum
//   - scancode_to_digit: maps a make code to {valid, value[3:0]}
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  localparam logic [3:0] DIGIT_BLANK = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_e;

  // Returns {1'b1, value} for a number-row digit key, '0 otherwise.
  function automatic logic [4:0] scancode_to_digit(input logic [7:0] sc);
    logic [4:0] r;
    case (sc)
      SC_D0:   r = {1'b1, 4'd0};
      SC_D1:   r = {1'b1, 4'd1};
      SC_D2:   r = {1'b1, 4'd2};
      SC_D3:   r = {1'b1, 4'd3};
      SC_D4:   r = {1'b1, 4'd4};
      SC_D5:   r = {1'b1, 4'd5};
      SC_D6:   r = {1'b1, 4'd6};
      SC_D7:   r = {1'b1, 4'd7};
      SC_D8:   r = {1'b1, 4'd8};
      SC_D9:   r = {1'b1, 4'd9};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_digit_entry_ctrl_digit_scan_mux.sv
// digit_scan_mux: time-multiplexes four buffer digits onto one digit/anode pair.
//   clk, rst   : clock, synchronous active-high reset
//   digits_i   : {d3, d2, d1, d0}, 4 bits each
//   digit_o    : registered value of the scanned position
//   an_o       : registered active-low one-hot anode (bit i = position i)
// The prescaler counts 0..SCAN_DIV-1; on wrap the scan index advances.
module digit_scan_mux
  import ps2_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_i,
  output logic [3:0]  digit_o,
  output logic [3:0]  an_o
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;

  // digit and anode are both loaded from the next index so they always
  // switch on the same edge.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d    = ~(4'b0001 << idx_d);
    digit_d = digits_i[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      digit_q <= DIGIT_BLANK;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign an_o    = an_q;

endmodule

// File: rtl/ps2_digit_entry_ctrl.sv
// ps2_digit_entry_ctrl: scancode decoder + 4-digit entry buffer + display scan.
//   clk, rst    : clock, synchronous active-high reset
//   code        : scancode byte, valid while code_valid is high
//   code_valid  : one-cycle byte strobe
//   digit, an   : scanned digit value (0-9, 4'hA blank) and active-low anode
//   entry_count : number of entered digits, 0-4
//   overflow    : sticky, set when a digit is shifted out of a full buffer
// Break (F0 xx) and extended (E0 xx, E0 F0 xx) sequences are swallowed;
// only make codes seen in IDLE edit the buffer.
module ps2_digit_entry_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [3:0] digit,
  output logic [3:0] an,
  output logic [2:0] entry_count,
  output logic       overflow
);

  dec_state_e       state_q, state_d;
  logic [3:0][3:0]  buf_q, buf_d;   // buf_q[0] is d0 (rightmost)
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       key;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    key     = scancode_to_digit(code);

    if (code_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (code == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (code == SC_EXT) begin
            state_d = ST_EXT;
          end else if (key[4]) begin
            buf_d = {buf_q[2:0], key[3:0]};
            if (cnt_q == 3'd4) ovf_d = 1'b1;
            else               cnt_d = cnt_q + 3'd1;
          end else if (code == SC_BKSP) begin
            if (cnt_q != 3'd0) begin
              buf_d = {DIGIT_BLANK, buf_q[3:1]};
              cnt_d = cnt_q - 3'd1;
            end
          end else if (code == SC_ESC) begin
            buf_d = {4{DIGIT_BLANK}};
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
        ST_BREAK:     state_d = ST_IDLE;
        ST_EXT:       state_d = (code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        ST_EXT_BREAK: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= {4{DIGIT_BLANK}};
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign entry_count = cnt_q;
  assign overflow    = ovf_q;

  digit_scan_mux #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .digits_i (buf_q),
    .digit_o  (digit),
    .an_o     (an)
  );

endmodule

// File: doc/ps2_digit_entry_ctrl.md
# ps2_digit_entry_ctrl

Controller between the PS/2 byte receiver and the seven-segment controller. It takes scancode bytes and filters out break sequences (F0 xx) and extended sequences (E0 xx, E0 F0 xx). It applies number-row digit, backspace and escape keys to a 4-digit entry buffer. It time-multiplexes that buffer onto the single digit/anode pair consumed by the display controller.

## Interface
Parameters:
- SCAN_DIV, 100000: clk cycles per displayed digit (1 kHz per digit at 100 MHz); legal range ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- code  in  8  scancode byte from the PS/2 receiver
- code_valid  in  1  one-cycle strobe; code is valid while high
- digit  out  4  value of the currently scanned digit; 0–9, or 4'hA = blank
- an  out  4  active-low one-hot anode select; bit i = digit position i (0 = rightmost)
- entry_count  out  3  number of entered digits, 0–4
- overflow  out  1  sticky; set when a digit is pushed out of a full buffer

## Operation
- Decode FSM states: IDLE, BREAK, EXT, EXT_BREAK. It advances only on cycles with code_valid=1.
  - IDLE: F0 → BREAK. E0 → EXT. Any other byte is a make code: process it, stay in IDLE.
  - BREAK: any byte is consumed and ignored → IDLE.
  - EXT: F0 → EXT_BREAK. Any other byte is ignored → IDLE. Extended keys have no effect.
  - EXT_BREAK: any byte is ignored → IDLE.
- Make-code processing (IDLE only):
  - Digit keys map as 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - A digit key shifts the buffer left: d3←d2, d2←d1, d1←d0, d0←new.
    - entry_count increments, saturating at 4.
    - If entry_count was 4, the old d3 is lost and overflow←1.
  - Backspace (66): shift right, d0←d1, d1←d2, d2←d3, d3←BLANK; entry_count decrements. No-op when entry_count=0.
  - Escape (76): d0..d3←BLANK, entry_count←0, overflow←0.
  - Any other make code is ignored.
- Typematic repeats: each repeated make code counts as a new keypress. There is no repeat suppression.
- Positions ≥ entry_count always hold BLANK (4'hA).
- Scan sequencer:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, scan index idx advances 0→1→2→3→0.
  - an = ~(4'b0001 << idx); digit = d[idx]. Both are registered.
- Reset values: state IDLE; d0..d3 = 4'hA; entry_count=0; overflow=0; prescaler=0; idx=0; an=4'b1110; digit=4'hA.

## Timing
- code_valid sampled high at edge N: FSM state, buffer, entry_count and overflow are updated after edge N.
- digit/an reflect the updated buffer after edge N+1, provided idx selects the changed position.
- Back-to-back code_valid on consecutive cycles: every byte is processed. There are no lost bytes and no stall.
- an changes exactly once per SCAN_DIV cycles. digit and an change on the same edge, so there is no glitch cycle with mismatched digit/anode.
- A buffer update on the same edge as a scan advance: the new idx shows the post-update buffer one cycle later.
- rst has priority over code_valid. Reset mid-sequence (after F0 or E0) forgets the prefix, so the next byte is treated as a make code.
- Arithmetic:
  - entry_count is 3 bits and never exceeds 4 or goes below 0.
  - The prescaler is $clog2(SCAN_DIV) bits.

## Structure
- Shared package ps2_pkg holds:
  - scancode constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_BKSP=8'h66, SC_ESC=8'h76, and the ten digit codes;
  - DIGIT_BLANK=4'hA;
  - the decode FSM state enum;
  - a function scancode_to_digit returning {valid, value[3:0]}.
- One sub-module: digit_scan_mux, containing the prescaler, scan index and registered digit/an. It takes the four buffer digits as input.
- The decode FSM and entry buffer stay in the top of this block.

## Test plan
- Reset, then bytes 16, 1E, 26 → buffer d2..d0 = 1,2,3, d3=BLANK, entry_count=3. With SCAN_DIV=4, an cycles 1110→1101→1011→0111 every 4 clocks, and digit shows 3,2,1,A.
- Make 16, break F0 16 → exactly one '1' entered; entry_count=1. The break byte 16 is not re-entered.
- Extended sequence E0 75, E0 F0 75, then 45 → only '0' entered; FSM back in IDLE after each sequence.
- Five digits 16, 1E, 26, 25, 2E → d3..d0 = 2,3,4,5, entry_count=4, overflow=1. Then 66 → d3..d0 = A,2,3,4, entry_count=3, overflow stays 1. Then 76 → all A, entry_count=0, overflow=0.
- Backspace 66 with entry_count=0 → no change. Unmapped make code 1C → no change.
- F0 then rst for one cycle then 16 → '1' entered (prefix discarded), and all outputs held at reset values during rst. Back-to-back code_valid on 2 consecutive cycles (16, 1E) → both entered.
